// File: rtl/uart_cmd_sequencer_if.sv
// ============================================================================
//  Module      : uart_cmd_sequencer_if
//  Description : Bundles the RX/TX byte-FIFO handshakes and the system bus
//                seen by the UART command sequencer.
//                  RX FIFO : i_rx_dat, i_rx_empty, i_rx_push -> o_rx_pop
//                  TX FIFO : o_tx_dat, o_tx_push <- i_tx_full
//                  Bus     : o_addr, o_dat, o_cs, o_we <- i_dat, i_ack
//                  Status  : o_busy
//                The master modport is the sequencer's view; the slave
//                modport is the view of the surrounding FIFOs and bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_sequencer_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [7:0]    i_rx_dat;
    logic          i_rx_empty;
    logic          i_rx_push;
    logic          o_rx_pop;
    logic [7:0]    o_tx_dat;
    logic          o_tx_push;
    logic          i_tx_full;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_dat;
    logic [DW-1:0] i_dat;
    logic          o_cs;
    logic          o_we;
    logic          i_ack;
    logic          o_busy;

    modport master (
        input  i_rx_dat, i_rx_empty, i_rx_push, i_tx_full, i_dat, i_ack,
        output o_rx_pop, o_tx_dat, o_tx_push, o_addr, o_dat, o_cs, o_we, o_busy
    );

    modport slave (
        output i_rx_dat, i_rx_empty, i_rx_push, i_tx_full, i_dat, i_ack,
        input  o_rx_pop, o_tx_dat, o_tx_push, o_addr, o_dat, o_cs, o_we, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_sequencer.sv
// ============================================================================
//  Module      : uart_cmd_sequencer
//  Description : Drains command bytes from the RX FIFO, parses 'R' (read) and
//                'W' (write) commands, runs one bus transaction per command
//                and pushes the response bytes into the TX FIFO.
//                Ports:
//                  i_clk     - clock
//                  i_reset_n - asynchronous active-low reset
//                  bus       - FIFO handshakes and system bus (master view)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_sequencer #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic               i_clk,
    input  wire logic               i_reset_n,
    uart_cmd_sequencer_if.master    bus
);

    localparam int AB  = AW / 8;
    localparam int DB  = DW / 8;
    localparam int CW  = $clog2(AB + DB + 1);
    localparam int RCW = $clog2(DB + 1);

    localparam logic [7:0]    c_CMD_READ  = 8'h52;
    localparam logic [7:0]    c_CMD_WRITE = 8'h57;
    // Single-byte responses are left-aligned so RESP always sends the top byte.
    localparam logic [DW-1:0] c_RESP_OK   = DW'(8'h4B) << (DW - 8);
    localparam logic [DW-1:0] c_RESP_TMO  = DW'(8'h21) << (DW - 8);
    localparam logic [DW-1:0] c_RESP_UNK  = DW'(8'h3F) << (DW - 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARG  = 2'd1,
        S_BUS  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q;
    logic            is_write_q;
    logic [CW-1:0]   arg_left_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   dat_q;
    logic [DW-1:0]   resp_q;
    logic [RCW-1:0]  resp_left_q;
    logic [15:0]     to_cnt_q;
    logic            cs_q;
    logic            we_q;
    logic            tx_push_q;
    logic [7:0]      tx_dat_q;
    logic            w_pop;

    // The FIFO ignores a pop that coincides with a push, so the pop is withheld
    // in that cycle; otherwise the head byte would be consumed twice.
    assign w_pop = ((state_q == S_IDLE) || (state_q == S_ARG))
                   && !bus.i_rx_empty && !bus.i_rx_push;

    assign bus.o_rx_pop  = w_pop;
    assign bus.o_tx_dat  = tx_dat_q;
    assign bus.o_tx_push = tx_push_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_dat     = dat_q;
    assign bus.o_cs      = cs_q;
    assign bus.o_we      = we_q;
    assign bus.o_busy    = (state_q != S_IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            arg_left_q  <= '0;
            addr_q      <= '0;
            dat_q       <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
            to_cnt_q    <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            tx_push_q   <= 1'b0;
            tx_dat_q    <= '0;
        end else begin
            tx_push_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        case (bus.i_rx_dat)
                            c_CMD_READ: begin
                                is_write_q <= 1'b0;
                                arg_left_q <= CW'(AB);
                                state_q    <= S_ARG;
                            end
                            c_CMD_WRITE: begin
                                is_write_q <= 1'b1;
                                arg_left_q <= CW'(AB + DB);
                                state_q    <= S_ARG;
                            end
                            default: begin
                                resp_q      <= c_RESP_UNK;
                                resp_left_q <= RCW'(1);
                                state_q     <= S_RESP;
                            end
                        endcase
                    end
                end

                S_ARG: begin
                    if (w_pop) begin
                        // Address bytes come first; only a write carries the
                        // trailing DB data bytes.
                        if (!is_write_q || (arg_left_q > CW'(DB))) begin
                            addr_q <= (addr_q << 8) | AW'(bus.i_rx_dat);
                        end else begin
                            dat_q <= (dat_q << 8) | DW'(bus.i_rx_dat);
                        end
                        arg_left_q <= arg_left_q - CW'(1);
                        if (arg_left_q == CW'(1)) begin
                            cs_q     <= 1'b1;
                            we_q     <= is_write_q;
                            to_cnt_q <= '0;
                            state_q  <= S_BUS;
                        end
                    end
                end

                S_BUS: begin
                    // An ack in the final timeout cycle still completes the access.
                    if (bus.i_ack) begin
                        cs_q    <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_RESP;
                        if (is_write_q) begin
                            resp_q      <= c_RESP_OK;
                            resp_left_q <= RCW'(1);
                        end else begin
                            resp_q      <= bus.i_dat;
                            resp_left_q <= RCW'(DB);
                        end
                    end else if (to_cnt_q == 16'(TIMEOUT - 1)) begin
                        cs_q        <= 1'b0;
                        we_q        <= 1'b0;
                        resp_q      <= c_RESP_TMO;
                        resp_left_q <= RCW'(1);
                        state_q     <= S_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end

                S_RESP: begin
                    if (!bus.i_tx_full) begin
                        tx_push_q   <= 1'b1;
                        tx_dat_q    <= resp_q[DW-1 -: 8];
                        resp_q      <= resp_q << 8;
                        resp_left_q <= resp_left_q - RCW'(1);
                        if (resp_left_q == RCW'(1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
// ============================================================================
//  Module      : tb_uart_cmd_sequencer
//  Description : Directed self-checking bench for uart_cmd_sequencer with an
//                RX FIFO model, a TX capture log and a small bus slave memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_sequencer;

    logic clk = 1'b0;
    logic i_reset_n;
    always #5 clk = ~clk;

    uart_cmd_sequencer_if #(.AW(16), .DW(16)) bus_if ();

    uart_cmd_sequencer #(.AW(16), .DW(16), .TIMEOUT(255)) dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .bus       (bus_if.master)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- RX FIFO model (push wins over pop) ----------------
    logic [7:0] rx_mem [64];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic [7:0] rx_pend = 8'h00;

    assign bus_if.i_rx_empty = (rx_wr == rx_rd);
    assign bus_if.i_rx_dat   = rx_mem[rx_rd % 64];

    always @(posedge clk) begin
        if (bus_if.i_rx_push) begin
            rx_mem[rx_wr % 64] <= rx_pend;
            rx_wr <= rx_wr + 1;
        end else if (bus_if.o_rx_pop) begin
            rx_rd <= rx_rd + 1;
        end
    end

    // ---------------- bus slave / monitors ----------------
    logic [15:0] smem [256] = '{default: 16'h0000};
    int          ack_delay = 2;
    bit          slave_en = 1'b1;
    int          cs_cycles;

    assign bus_if.i_dat = smem[bus_if.o_addr[7:0]];

    always @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus_if.i_ack <= 1'b0;
            cs_cycles    <= 0;
        end else if (bus_if.o_cs && !bus_if.i_ack) begin
            cs_cycles <= cs_cycles + 1;
            if (slave_en && (cs_cycles + 1 == ack_delay)) bus_if.i_ack <= 1'b1;
        end else begin
            bus_if.i_ack <= 1'b0;
            cs_cycles    <= 0;
        end
    end

    int          tx_cnt = 0;
    logic [7:0]  tx_mem [64];
    int          cs_rise = 0;
    int          cs_hi = 0;
    int          ack_cnt = 0;
    int          unstable = 0;
    logic        prev_cs = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic [15:0] prev_dat = 16'h0;
    logic [15:0] last_addr = 16'h0;
    logic [15:0] last_dat = 16'h0;
    logic        last_we = 1'b0;

    always @(posedge clk) begin
        prev_cs   <= bus_if.o_cs;
        prev_addr <= bus_if.o_addr;
        prev_dat  <= bus_if.o_dat;
        if (bus_if.o_cs && !prev_cs) cs_rise <= cs_rise + 1;
        if (bus_if.o_cs) cs_hi <= cs_hi + 1;
        if (bus_if.o_cs && prev_cs && (bus_if.o_addr != prev_addr || bus_if.o_dat != prev_dat))
            unstable <= unstable + 1;
        if (bus_if.o_cs && bus_if.i_ack) begin
            last_addr <= bus_if.o_addr;
            last_dat  <= bus_if.o_dat;
            last_we   <= bus_if.o_we;
            ack_cnt   <= ack_cnt + 1;
            if (bus_if.o_we) smem[bus_if.o_addr[7:0]] <= bus_if.o_dat;
        end
        if (bus_if.o_tx_push) begin
            tx_mem[tx_cnt % 64] <= bus_if.o_tx_dat;
            tx_cnt <= tx_cnt + 1;
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic send_bytes(input int n, input logic [39:0] bytes);
        for (int i = 0; i < n; i++) begin
            rx_pend          = bytes[8*(n-1-i) +: 8];
            bus_if.i_rx_push = 1'b1;
            @(negedge clk);
        end
        bus_if.i_rx_push = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        int t = 0;
        while (tx_cnt < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (tx_cnt >= n);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        i_reset_n        = 1'b0;
        bus_if.i_rx_push = 1'b0;
        bus_if.i_tx_full = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus_if.o_cs !== 1'b0) begin n_err++; $display("FAIL reset_cs: got %b expected 0", bus_if.o_cs); end
        n_vec++; if (bus_if.o_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", bus_if.o_we); end
        n_vec++; if (bus_if.o_tx_push !== 1'b0) begin n_err++; $display("FAIL reset_tx_push: got %b expected 0", bus_if.o_tx_push); end
        n_vec++; if (bus_if.o_tx_dat !== 8'h00) begin n_err++; $display("FAIL reset_tx_dat: got %h expected 00", bus_if.o_tx_dat); end
        n_vec++; if (bus_if.o_addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr: got %h expected 0000", bus_if.o_addr); end
        n_vec++; if (bus_if.o_dat !== 16'h0000) begin n_err++; $display("FAIL reset_dat: got %h expected 0000", bus_if.o_dat); end
        n_vec++; if (bus_if.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus_if.o_busy); end
        n_vec++; if (bus_if.o_rx_pop !== 1'b0) begin n_err++; $display("FAIL reset_rx_pop: got %b expected 0", bus_if.o_rx_pop); end
        i_reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read;
        int base = tx_cnt;
        int rise0 = cs_rise;
        int hi0 = cs_hi;
        bit ok;
        slave_en  = 1'b1;
        ack_delay = 2;
        send_bytes(5, 40'h57_1234_BEEF);
        wait_tx(base + 1, 100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wr_resp_timeout: got %0d bytes expected 1", tx_cnt - base); end
        n_vec++; if (tx_mem[base % 64] !== 8'h4B) begin n_err++; $display("FAIL wr_resp: got %h expected 4B", tx_mem[base % 64]); end
        n_vec++; if (last_addr !== 16'h1234) begin n_err++; $display("FAIL wr_addr: got %h expected 1234", last_addr); end
        n_vec++; if (last_dat !== 16'hBEEF) begin n_err++; $display("FAIL wr_dat: got %h expected BEEF", last_dat); end
        n_vec++; if (last_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b expected 1", last_we); end
        n_vec++; if (cs_rise - rise0 != 1) begin n_err++; $display("FAIL wr_cs_pulses: got %0d expected 1", cs_rise - rise0); end
        n_vec++; if (cs_hi - hi0 != 3) begin n_err++; $display("FAIL wr_cs_len: got %0d expected 3", cs_hi - hi0); end
        n_vec++; if (bus_if.o_busy !== 1'b0) begin n_err++; $display("FAIL wr_busy: got %b expected 0", bus_if.o_busy); end

        send_bytes(3, 40'h00_0052_1234);
        wait_tx(base + 3, 100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rd_resp_timeout: got %0d bytes expected 3", tx_cnt - base); end
        n_vec++; if (tx_mem[(base + 1) % 64] !== 8'hBE) begin n_err++; $display("FAIL rd_byte0: got %h expected BE", tx_mem[(base + 1) % 64]); end
        n_vec++; if (tx_mem[(base + 2) % 64] !== 8'hEF) begin n_err++; $display("FAIL rd_byte1: got %h expected EF", tx_mem[(base + 2) % 64]); end
        n_vec++; if (last_we !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b expected 0", last_we); end
        n_vec++; if (last_addr !== 16'h1234) begin n_err++; $display("FAIL rd_addr: got %h expected 1234", last_addr); end
        n_vec++; if (unstable != 0) begin n_err++; $display("FAIL bus_stable: got %0d changes expected 0", unstable); end
    endtask

    task automatic test_unknown;
        int base = tx_cnt;
        int rise0 = cs_rise;
        bit ok;
        send_bytes(1, 40'h00_0000_0000);
        wait_tx(base + 1, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL unk_resp_timeout: got %0d bytes expected 1", tx_cnt - base); end
        n_vec++; if (tx_mem[base % 64] !== 8'h3F) begin n_err++; $display("FAIL unk_resp: got %h expected 3F", tx_mem[base % 64]); end
        n_vec++; if (cs_rise != rise0) begin n_err++; $display("FAIL unk_no_cs: got %0d pulses expected 0", cs_rise - rise0); end
        n_vec++; if (bus_if.o_busy !== 1'b0) begin n_err++; $display("FAIL unk_busy: got %b expected 0", bus_if.o_busy); end
    endtask

    task automatic test_timeout;
        int base = tx_cnt;
        int hi0 = cs_hi;
        int ack0 = ack_cnt;
        bit ok;
        slave_en = 1'b0;
        send_bytes(3, 40'h00_0052_0042);
        wait_tx(base + 1, 600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL tmo_resp_timeout: got %0d bytes expected 1", tx_cnt - base); end
        n_vec++; if (tx_mem[base % 64] !== 8'h21) begin n_err++; $display("FAIL tmo_resp: got %h expected 21", tx_mem[base % 64]); end
        n_vec++; if (cs_hi - hi0 != 255) begin n_err++; $display("FAIL tmo_cs_len: got %0d expected 255", cs_hi - hi0); end
        n_vec++; if (ack_cnt != ack0) begin n_err++; $display("FAIL tmo_no_ack: got %0d acks expected 0", ack_cnt - ack0); end
        // Following command must run normally; it also seeds 0x0056 for later reads.
        slave_en = 1'b1;
        send_bytes(5, 40'h57_0056_A55A);
        wait_tx(base + 2, 100, ok);
        n_vec++; if (!ok || tx_cnt != base + 2) begin n_err++; $display("FAIL tmo_next_count: got %0d bytes expected 2", tx_cnt - base); end
        n_vec++; if (tx_mem[(base + 1) % 64] !== 8'h4B) begin n_err++; $display("FAIL tmo_next_resp: got %h expected 4B", tx_mem[(base + 1) % 64]); end
    endtask

    task automatic test_backpressure;
        int base;
        bit ok;
        bus_if.i_tx_full = 1'b1;
        send_bytes(3, 40'h00_0052_0056);
        repeat (15) @(negedge clk);
        base = tx_cnt;
        repeat (10) @(negedge clk);
        n_vec++; if (tx_cnt != base) begin n_err++; $display("FAIL bp_no_push: got %0d pushes expected 0", tx_cnt - base); end
        n_vec++; if (bus_if.o_busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b expected 1", bus_if.o_busy); end
        bus_if.i_tx_full = 1'b0;
        wait_tx(base + 2, 50, ok);
        n_vec++; if (!ok || tx_cnt != base + 2) begin n_err++; $display("FAIL bp_count: got %0d bytes expected 2", tx_cnt - base); end
        n_vec++; if (tx_mem[base % 64] !== 8'hA5) begin n_err++; $display("FAIL bp_byte0: got %h expected A5", tx_mem[base % 64]); end
        n_vec++; if (tx_mem[(base + 1) % 64] !== 8'h5A) begin n_err++; $display("FAIL bp_byte1: got %h expected 5A", tx_mem[(base + 1) % 64]); end
    endtask

    task automatic test_collision;
        int base = tx_cnt;
        bit ok;
        rx_pend = 8'h52; bus_if.i_rx_push = 1'b1;
        @(negedge clk);
        rx_pend = 8'h00;
        #1;
        n_vec++; if (bus_if.o_rx_pop !== 1'b0) begin n_err++; $display("FAIL col_pop0: got %b expected 0", bus_if.o_rx_pop); end
        @(negedge clk);
        rx_pend = 8'h56;
        #1;
        n_vec++; if (bus_if.o_rx_pop !== 1'b0) begin n_err++; $display("FAIL col_pop1: got %b expected 0", bus_if.o_rx_pop); end
        @(negedge clk);
        bus_if.i_rx_push = 1'b0;
        #1;
        n_vec++; if (bus_if.o_rx_pop !== 1'b1) begin n_err++; $display("FAIL col_pop_resume: got %b expected 1", bus_if.o_rx_pop); end
        @(negedge clk);
        wait_tx(base + 2, 60, ok);
        n_vec++; if (!ok || tx_cnt != base + 2) begin n_err++; $display("FAIL col_count: got %0d bytes expected 2", tx_cnt - base); end
        n_vec++; if (tx_mem[base % 64] !== 8'hA5) begin n_err++; $display("FAIL col_byte0: got %h expected A5", tx_mem[base % 64]); end
        n_vec++; if (tx_mem[(base + 1) % 64] !== 8'h5A) begin n_err++; $display("FAIL col_byte1: got %h expected 5A", tx_mem[(base + 1) % 64]); end
    endtask

    task automatic test_reset_mid;
        int base;
        int t = 0;
        bit ok;
        slave_en = 1'b0;
        send_bytes(3, 40'h00_0052_0010);
        while (!bus_if.o_cs && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_vec++; if (bus_if.o_cs !== 1'b1) begin n_err++; $display("FAIL mid_cs_start: got %b expected 1", bus_if.o_cs); end
        repeat (5) @(negedge clk);
        base = tx_cnt;
        #2 i_reset_n = 1'b0;
        #1;
        n_vec++; if (bus_if.o_cs !== 1'b0) begin n_err++; $display("FAIL mid_cs_async: got %b expected 0", bus_if.o_cs); end
        n_vec++; if (bus_if.o_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", bus_if.o_busy); end
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++; if (tx_cnt != base) begin n_err++; $display("FAIL mid_no_tx: got %0d bytes expected 0", tx_cnt - base); end
        slave_en = 1'b1;
        send_bytes(3, 40'h00_0052_1234);
        wait_tx(base + 2, 60, ok);
        n_vec++; if (!ok || tx_cnt != base + 2) begin n_err++; $display("FAIL mid_after_count: got %0d bytes expected 2", tx_cnt - base); end
        n_vec++; if (tx_mem[base % 64] !== 8'hBE) begin n_err++; $display("FAIL mid_after_byte0: got %h expected BE", tx_mem[base % 64]); end
        n_vec++; if (tx_mem[(base + 1) % 64] !== 8'hEF) begin n_err++; $display("FAIL mid_after_byte1: got %h expected EF", tx_mem[(base + 1) % 64]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unknown();
        test_timeout();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
